// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: scans captured operands MSB first and
// stops at the first differing bit pair, reporting A==B / A<B / A>B.
module serial_mag_comparator #(
    parameter int WIDTH = 8,
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             y0,
    output logic             y1,
    output logic             y2,
    output logic [IW-1:0]    bit_idx
);

    // state | meaning
    // IDLE  | waiting for start; bit_idx parked at 0
    // SCAN  | comparing one bit pair per cycle, MSB first
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_reg, a_nx;
    logic [WIDTH-1:0]   b_reg, b_nx;
    logic [IW-1:0]      idx, idx_nx;
    logic               done_nx;
    logic [2:0]         y_reg, y_nx;
    logic [31:0]        a_sh, b_sh;
    logic               a_bit, b_bit;
    logic               bit_eq, bit_lt, bit_gt;

    // Shift rather than index so WIDTH=1 needs no special-cased select.
    assign a_sh   = 32'(a_reg) >> idx;
    assign b_sh   = 32'(b_reg) >> idx;
    assign a_bit  = a_sh[0];
    assign b_bit  = b_sh[0];
    assign bit_eq = ~(a_bit ^ b_bit);
    assign bit_lt = ~a_bit & b_bit;
    assign bit_gt = a_bit & ~b_bit;

    always_comb begin
        state_nx = state;
        a_nx     = a_reg;
        b_nx     = b_reg;
        idx_nx   = idx;
        done_nx  = 1'b0;
        y_nx     = y_reg;
        case (state)
            IDLE: begin
                if (start) begin
                    a_nx     = a_in;
                    b_nx     = b_in;
                    idx_nx   = IW'(WIDTH - 1);
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (abort) begin
                    idx_nx   = '0;
                    state_nx = IDLE;
                end else if (!bit_eq) begin
                    y_nx     = {bit_gt, bit_lt, 1'b0};
                    done_nx  = 1'b1;
                    idx_nx   = '0;
                    state_nx = IDLE;
                end else if (idx == '0) begin
                    y_nx     = 3'b001;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    idx_nx   = idx - IW'(1);
                end
            end
            default: begin
                idx_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            done  <= 1'b0;
            y_reg <= 3'b000;
        end else begin
            state <= state_nx;
            a_reg <= a_nx;
            b_reg <= b_nx;
            idx   <= idx_nx;
            done  <= done_nx;
            y_reg <= y_nx;
        end
    end

    assign busy    = (state == SCAN);
    assign bit_idx = idx;
    assign y0      = y_reg[0];
    assign y1      = y_reg[1];
    assign y2      = y_reg[2];

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin a compare; sampled only in IDLE.
REQ-005 abort  input  1  cancels an in-progress compare.
REQ-006 a_in  input  WIDTH  operand A; captured when start is accepted.
REQ-007 b_in  input  WIDTH  operand B; captured when start is accepted.
REQ-008 busy  output  1  high while in SCAN.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 y0  output  1  result: A == B.
REQ-011 y1  output  1  result: A < B.
REQ-012 y2  output  1  result: A > B.
REQ-013 bit_idx  output  ceil(log2(WIDTH)), minimum 1  index of the bit being compared; debug use only.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-015 Start acceptance: the block SHALL accept start when it is high in IDLE at a rising edge, then:
- capture a_in and b_in into internal registers;
- load the bit index to WIDTH-1;
- enter SCAN.
REQ-016 start SHALL be ignored in SCAN; the captured operands SHALL NOT change until the next accepted start.
REQ-017 SCAN compare: each SCAN edge SHALL compare one bit pair of the captured operands at the current index, MSB first, using single-bit equal/less/greater logic.
REQ-018 Bits differ: if the pair differs, the block SHALL:
- set y1=1 if the A bit is 0 and y2=1 if the A bit is 1;
- clear the other two result flags;
- assert done for the next cycle;
- return to IDLE (early termination).
REQ-019 Bits equal: if the pair is equal and the index is 0, the block SHALL set y0=1, clear y1 and y2, assert done for the next cycle and return to IDLE.
REQ-020 If the pair is equal and the index is nonzero, the block SHALL decrement the index and remain in SCAN.
REQ-021 Latency: done SHALL be high in cycle N = WIDTH-i after the start edge, where i is the highest differing bit position; N = WIDTH when A == B.
REQ-022 Result hold: y0, y1 and y2 SHALL be registered and held stable until the next decision edge.
REQ-023 At most one of y0, y1, y2 SHALL be high at any time.
REQ-024 done SHALL be high for exactly one cycle per completed compare.
REQ-025 busy SHALL be high exactly in the cycles where the state is SCAN.
REQ-026 Back-to-back: a start present in the cycle where done is high SHALL be accepted, because the state is already IDLE.
REQ-027 Abort: abort high in SCAN SHALL return the block to IDLE at that edge with no done pulse and y0/y1/y2 unchanged.
REQ-028 abort in IDLE SHALL have no effect.
REQ-029 abort SHALL take priority over the compare decision at the same edge.
REQ-030 WIDTH=1: a compare SHALL complete in one SCAN cycle, with done in cycle 1 after start.
REQ-031 bit_idx SHALL read 0 in IDLE.

Reset
REQ-032 rst_n low at a rising edge SHALL force, regardless of state or of start/abort:
- state IDLE;
- busy=0, done=0;
- y0=0, y1=0, y2=0;
- bit_idx=0;
- captured operands to 0.
REQ-033 Reset asserted mid-SCAN SHALL discard the compare with no done pulse.
REQ-034 After rst_n returns high, the first start SHALL be accepted normally.

Verification (WIDTH=8)
REQ-035 Equal operands: a_in=0xA5, b_in=0xA5, start pulse -> busy high for 8 cycles; done in cycle 8; y0=1, y1=0, y2=0.
REQ-036 MSB decides: a_in=0x80, b_in=0x7F -> done in cycle 1; y2=1; busy high for 1 cycle.
REQ-037 LSB decides: a_in=0x12, b_in=0x13 -> done in cycle 8; y1=1.
REQ-038 Operand change and re-start: a_in/b_in changed to 0xFF/0x00 and start pulsed again during SCAN of 0x12 vs 0x13 -> both ignored; result is still y1=1 in cycle 8.
REQ-039 Back-to-back: start held high through done -> a second compare starts; busy rises in the cycle after done.
REQ-040 Abort and reset: abort in cycle 3 of a 0x01 vs 0x01 compare -> busy drops, no done, prior y0/y1/y2 retained; rst_n low in cycle 4 of a new scan -> all outputs 0 at the next edge, no done.
